// File: rtl/counter_checker_pkg.sv
// Shared constants for the RX incrementing-counter checker.
// Optional feature macro: CHECKER_INVERT_DETECT_EN.
package counter_checker_pkg;

  localparam int DATA_W_DEFAULT    = 32;
  localparam int ERR_CNT_W_DEFAULT = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SYNC   = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/counter_checker_if.sv
// Word stream in, checker status out.
// Optional feature macro: CHECKER_INVERT_DETECT_EN.
interface counter_checker_if
  import counter_checker_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int ERR_CNT_W = ERR_CNT_W_DEFAULT
);

  logic                 start_i;
  logic                 data_valid_i;
  logic [DATA_W-1:0]    data_i;
  logic                 lock_o;
  logic                 error_o;
  logic [ERR_CNT_W-1:0] error_count_o;
  logic [31:0]          word_count_o;
  logic                 inverted_o;

  modport master (
    output start_i, data_valid_i, data_i,
    input  lock_o, error_o, error_count_o,
    input  word_count_o, inverted_o
  );

  modport slave (
    input  start_i, data_valid_i, data_i,
    output lock_o, error_o, error_count_o,
    output word_count_o, inverted_o
  );

endinterface

// File: rtl/counter_checker_sat.sv
// Saturating up-counter; clr and inc together load 1.
// Optional feature macro: CHECKER_INVERT_DETECT_EN (unused here).
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q <= '0;
    end else if (clr) begin
      q <= WIDTH'(inc);
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Locks onto an incrementing word stream, then flags and counts mismatches.
// Optional feature macro: CHECKER_INVERT_DETECT_EN (inverted-word detect).
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int ERR_CNT_W     = ERR_CNT_W_DEFAULT,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 8
) (
  input logic              clk_i,
  input logic              reset_n_i,
  counter_checker_if.slave bus
);

  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(UNLOCK_THRESH + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_THRESH - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_THRESH - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [31:0]       wc_q, wc_d;
  logic              lock_q, lock_d;
  logic              error_q, error_d;
  logic              match;
  logic              err_inc, err_clr;
  logic              good_inc, good_clr;
  logic              bad_inc, bad_clr;
  logic [GW-1:0]     good_q;
  logic [BW-1:0]     bad_q;

  assign match = (bus.data_i == exp_q);

`ifdef CHECKER_INVERT_DETECT_EN
  logic inv_q, inv_d;
  assign bus.inverted_o = inv_q;
`else
  assign bus.inverted_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    wc_d     = wc_q;
    lock_d   = lock_q;
    error_d  = 1'b0;
    err_inc  = 1'b0;
    err_clr  = 1'b0;
    good_inc = 1'b0;
    good_clr = 1'b0;
    bad_inc  = 1'b0;
    bad_clr  = 1'b0;
`ifdef CHECKER_INVERT_DETECT_EN
    inv_d    = 1'b0;
`endif
    if (!bus.start_i) begin
      state_d = ST_IDLE;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SYNC;
          wc_d     = '0;
          err_clr  = 1'b1;
          good_clr = 1'b1;
          bad_clr  = 1'b1;
        end
        ST_SYNC: begin
          if (bus.data_valid_i) begin
            exp_d    = bus.data_i + DATA_W'(1);
            good_inc = 1'b1;
            // Any break in the run reseeds at 1.
            good_clr = !(match && (good_q != '0));
            if (match && (good_q == GOOD_LAST)) begin
              state_d = ST_LOCKED;
              lock_d  = 1'b1;
              bad_clr = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (bus.data_valid_i) begin
            wc_d  = wc_q + 32'd1;
            exp_d = exp_q + DATA_W'(1);
            if (match) begin
              bad_clr = 1'b1;
            end else begin
              err_inc = 1'b1;
              bad_inc = 1'b1;
`ifdef CHECKER_INVERT_DETECT_EN
              if (bus.data_i == ~exp_q) inv_d = 1'b1;
              else                      error_d = 1'b1;
`else
              error_d = 1'b1;
`endif
              if (bad_q == BAD_LAST) begin
                state_d  = ST_SYNC;
                lock_d   = 1'b0;
                exp_d    = bus.data_i + DATA_W'(1);
                good_clr = 1'b1;
                good_inc = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      wc_q    <= '0;
      lock_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef CHECKER_INVERT_DETECT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      wc_q    <= wc_d;
      lock_q  <= lock_d;
      error_q <= error_d;
`ifdef CHECKER_INVERT_DETECT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc       (err_inc),
    .clr       (err_clr),
    .q         (bus.error_count_o)
  );

  sat_counter #(.WIDTH(GW)) u_good (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc       (good_inc),
    .clr       (good_clr),
    .q         (good_q)
  );

  sat_counter #(.WIDTH(BW)) u_bad (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc       (bad_inc),
    .clr       (bad_clr),
    .q         (bad_q)
  );

  assign bus.lock_o       = lock_q;
  assign bus.error_o      = error_q;
  assign bus.word_count_o = wc_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: directed vectors, reference model, per-cycle compare.
// Honours CHECKER_INVERT_DETECT_EN for the inverted-word expectations.
module tb_counter_checker;

  localparam int DW      = 32;
  localparam int EW      = 4;
  localparam int LOCK    = 4;
  localparam int UNLOCK  = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  counter_checker_if #(.DATA_W(DW), .ERR_CNT_W(EW)) bus ();

  counter_checker #(
    .DATA_W        (DW),
    .ERR_CNT_W     (EW),
    .LOCK_THRESH   (LOCK),
    .UNLOCK_THRESH (UNLOCK)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // Reference model state
  bit          m_active, m_locked, m_err, m_inv;
  int          m_run, m_bad, m_errs;
  logic [31:0] m_exp, m_words;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void m_reset();
    m_active = 0; m_locked = 0; m_err = 0; m_inv = 0;
    m_run = 0; m_bad = 0; m_errs = 0;
    m_exp = '0; m_words = '0;
  endfunction

  function automatic void m_step();
    logic [31:0] d = bus.data_i;
    m_err = 0;
    m_inv = 0;
    if (!bus.start_i) begin
      m_active = 0;
      m_locked = 0;
    end else if (!m_active) begin
      m_active = 1; m_locked = 0;
      m_errs = 0; m_words = '0; m_run = 0; m_bad = 0;
    end else if (bus.data_valid_i) begin
      if (!m_locked) begin
        m_run = (m_run > 0 && d == m_exp) ? m_run + 1 : 1;
        m_exp = d + 32'd1;
        if (m_run == LOCK) begin
          m_locked = 1;
          m_bad = 0;
        end
      end else begin
        m_words = m_words + 32'd1;
        if (d == m_exp) begin
          m_bad = 0;
          m_exp = m_exp + 32'd1;
        end else begin
          if (m_errs < ERR_MAX) m_errs++;
          m_bad++;
`ifdef CHECKER_INVERT_DETECT_EN
          if (d == ~m_exp) m_inv = 1;
          else m_err = 1;
`else
          m_err = 1;
`endif
          if (m_bad == UNLOCK) begin
            m_locked = 0;
            m_exp = d + 32'd1;
            m_run = 1;
          end else begin
            m_exp = m_exp + 32'd1;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_lock", bus.lock_o, m_locked);
      chk("cyc_error", bus.error_o, m_err);
      chk("cyc_inverted", bus.inverted_o, m_inv);
      chk("cyc_errcnt", bus.error_count_o, m_errs);
      chk("cyc_wordcnt", bus.word_count_o, m_words);
    end
  end

  task automatic drive(input logic s, input logic v, input logic [31:0] d);
    @(negedge clk);
    bus.start_i = s;
    bus.data_valid_i = v;
    bus.data_i = d;
    @(posedge clk);
    m_step();
    #1;
  endtask

  // Restart the checker and lock on seed..seed+3; leaves expected=seed+4.
  task automatic sync(input logic [31:0] seed);
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, seed + i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.start_i = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_i = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock", bus.lock_o, 1'b0);
    chk("rst_errcnt", bus.error_count_o, 0);
    chk("rst_wordcnt", bus.word_count_o, 0);
    chk("rst_error", bus.error_o, 1'b0);
    #1 rst_n = 1'b1;

    // Lock after four in-sequence words
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 32'd1);
    drive(1'b1, 1'b1, 32'd2);
    chk("t1_lock_w2", bus.lock_o, 1'b0);
    drive(1'b1, 1'b1, 32'd3);
    chk("t1_lock_w3", bus.lock_o, 1'b1);
    drive(1'b1, 1'b1, 32'd4);
    chk("t1_errcnt", bus.error_count_o, 0);
    chk("t1_wordcnt", bus.word_count_o, 1);

    // Wrap-around with a valid gap
    sync(32'hFFFF_FFFA);
    drive(1'b1, 1'b1, 32'hFFFF_FFFE);
    drive(1'b1, 1'b0, 32'h1234_5678);
    drive(1'b1, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 32'h0000_0000);
    drive(1'b1, 1'b1, 32'h0000_0001);
    chk("t2_wordcnt", bus.word_count_o, 4);
    chk("t2_errcnt", bus.error_count_o, 0);
    chk("t2_lock", bus.lock_o, 1'b1);

    // Single mismatch
    sync(32'h0C);
    drive(1'b1, 1'b1, 32'h55);
    chk("t3_error", bus.error_o, 1'b1);
    chk("t3_errcnt", bus.error_count_o, 1);
    drive(1'b1, 1'b1, 32'h11);
    chk("t3_error_clr", bus.error_o, 1'b0);
    chk("t3_lock", bus.lock_o, 1'b1);
    chk("t3_wordcnt", bus.word_count_o, 2);

    // Eight mismatches unlock, four good words relock
    sync(32'h100);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 32'hA000 + i);
    chk("t4_lock_7", bus.lock_o, 1'b1);
    chk("t4_errcnt_7", bus.error_count_o, 7);
    drive(1'b1, 1'b1, 32'hA007);
    chk("t4_lock_8", bus.lock_o, 1'b0);
    chk("t4_errcnt_8", bus.error_count_o, 8);
    chk("t4_error_8", bus.error_o, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h200 + i);
    chk("t4_relock_3", bus.lock_o, 1'b0);
    drive(1'b1, 1'b1, 32'h203);
    chk("t4_relock_4", bus.lock_o, 1'b1);
    chk("t4_wordcnt", bus.word_count_o, 8);

    // Inverted expected word
    sync(32'h1C);
    drive(1'b1, 1'b1, 32'hFFFF_FFDF);
`ifdef CHECKER_INVERT_DETECT_EN
    chk("t5_inverted", bus.inverted_o, 1'b1);
    chk("t5_error", bus.error_o, 1'b0);
`else
    chk("t5_inverted", bus.inverted_o, 1'b0);
    chk("t5_error", bus.error_o, 1'b1);
`endif
    chk("t5_errcnt", bus.error_count_o, 1);

    // Saturation: 7 bad + 1 good per block keeps the lock
    sync(32'h300);
    for (int k = 0; k < 24; k++) begin
      if (k % 8 == 7) drive(1'b1, 1'b1, 32'h304 + k);
      else drive(1'b1, 1'b1, 32'h8000_0000 | (32'h304 + k));
      if (k == 16) chk("t6_sat_reach", bus.error_count_o, 4'hF);
    end
    chk("t6_sat_hold", bus.error_count_o, 4'hF);
    chk("t6_lock", bus.lock_o, 1'b1);
    chk("t6_wordcnt", bus.word_count_o, 24);

    // Drop start with a valid word, then re-raise
    drive(1'b0, 1'b1, 32'h31C);
    chk("t6_drop_lock", bus.lock_o, 1'b0);
    chk("t6_drop_errcnt", bus.error_count_o, 4'hF);
    chk("t6_drop_wordcnt", bus.word_count_o, 24);
    drive(1'b0, 1'b1, 32'h31D);
    drive(1'b1, 1'b1, 32'h999);
    chk("t6_rise_errcnt", bus.error_count_o, 0);
    chk("t6_rise_wordcnt", bus.word_count_o, 0);

    // TX restart while running, then async reset mid-stream
    sync(32'h40);
    drive(1'b1, 1'b1, 32'h44);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'h0 + i);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("ar_lock", bus.lock_o, 1'b0);
    chk("ar_errcnt", bus.error_count_o, 0);
    chk("ar_wordcnt", bus.word_count_o, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 32'h70 + i);
    chk("ar_relock", bus.lock_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
